ucode_loader: RTL and testbench

//  Fills the writable control store of the microprogrammed ARM control unit at boot.
//  - Receives microcode over a byte-wide valid/ready stream.
//  - Assembles bytes into control words and issues one write per word.
//  - Checks a trailing XOR checksum.
//  - Holds the core in reset (core_hold) until a load completes with a good checksum.
//  It is the write side of the control store; the sequencer is the read side.

---
 rtl/ucode_loader.sv | 210 +++++++++++++++++++++
 tb/tb_ucode_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_loader.sv
// ----------------------------------------------------------------------------
// ucode_loader
//
// Boot-time loader for the writable control store of the microprogrammed ARM
// control unit. Microcode arrives as a byte stream (valid/ready). Bytes are
// paired high-then-low into 16-bit control words, and each word is written to
// the control store at consecutive addresses 0..DEPTH-1. A trailing checksum
// byte must equal the XOR of every data byte. The core is held in reset
// (core_hold_o) until a load finishes with a good checksum.
//
// Build option:
//   UCODE_TIMEOUT_EN - when defined, a load that sees no accepted byte for
//                      TIMEOUT_CYC consecutive cycles ends in the error state.
//
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous, active-high reset
//   start_i      in   one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   in_valid_i   in   byte-stream valid
//   in_data_i    in   byte-stream data [7:0]
//   in_ready_o   out  byte-stream ready (LOAD_HI, LOAD_LO, CHECK)
//   wr_en_o      out  control-store write strobe, one-cycle pulse
//   wr_adr_o     out  control-store write address [ADDR_W-1:0]
//   wr_data_o    out  control-store write data [WORD_W-1:0]
//   core_hold_o  out  holds the core/sequencer in reset while 1
//   done_o       out  load complete with good checksum (level)
//   err_o        out  checksum mismatch or timeout (level)
// ----------------------------------------------------------------------------
module ucode_loader #(
    parameter int ADDR_W      = 4,
    parameter int WORD_W      = 16,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_adr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o
);

    // Elaboration-time parameter sanity checks.
    if (WORD_W != 16) begin : g_bad_word_w
        $error("ucode_loader: WORD_W must be 16 (two bytes per word)");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("ucode_loader: DEPTH must be in 1..2**ADDR_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ucode_loader: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          acc_q, acc_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_adr_q, wr_adr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;

    logic                loading;
    logic                accept;
    logic                timeout;

    assign loading = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO) ||
                     (state_q == S_CHECK);
    assign accept  = in_valid_i && loading;

`ifdef UCODE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The counter rests at zero outside a load, so entering LOAD_HI always
    // starts a fresh idle window; every accepted byte restarts it as well.
    // An accepted byte in the final cycle takes precedence over the timeout.
    assign timeout = loading && !accept && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q;
        if (!loading || accept) begin
            tmo_d = '0;
        end else if (!timeout) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the timeout option the loader waits indefinitely for bytes.
    assign timeout = 1'b0;
`endif

    // Next-state and datapath logic.
    // NOTE: every variable gets a default at the top of the block so that no
    // path through the case statement leaves it unassigned (which would infer
    // a latch).
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LOAD_HI;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_LOAD_HI: begin
                if (accept) begin
                    hi_d    = in_data_i;
                    acc_d   = acc_q ^ in_data_i;
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (accept) begin
                    acc_d     = acc_q ^ in_data_i;
                    wr_en_d   = 1'b1;
                    wr_adr_d  = cnt_q;
                    wr_data_d = {hi_q, in_data_i};
                    // The counter stops at the last address instead of
                    // wrapping, so a full-depth store ends at the max address.
                    if (cnt_q == LAST_ADR) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_LOAD_HI;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (in_data_i == acc_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            state_d = S_ERR;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Status outputs are pure decodes of the registered state: done and err
    // are exclusive by construction and the core is released only in DONE.
    assign in_ready_o  = loading;
    assign wr_en_o     = wr_en_q;
    assign wr_adr_o    = wr_adr_q;
    assign wr_data_o   = wr_data_q;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);
    assign core_hold_o = (state_q != S_DONE);

endmodule

// File: tb/tb_ucode_loader.sv
// ----------------------------------------------------------------------------
// tb_ucode_loader
//
// Directed self-checking bench for ucode_loader (ADDR_W=4, DEPTH=16,
// TIMEOUT_CYC=8). Inputs change 1 time unit after the rising edge and
// outputs are checked at the same point, away from the active edge. Control
// store writes are captured on the falling edge into a log that each scenario
// compares against the words it sent.
// ----------------------------------------------------------------------------
module tb_ucode_loader;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        wr_en_o;
    logic [3:0]  wr_adr_o;
    logic [15:0] wr_data_o;
    logic        core_hold_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [3:0]  adr_log[$];
    logic [15:0] dat_log[$];

    ucode_loader #(
        .ADDR_W      (4),
        .WORD_W      (16),
        .DEPTH       (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_adr_o    (wr_adr_o),
        .wr_data_o   (wr_data_o),
        .core_hold_o (core_hold_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            adr_log.push_back(wr_adr_o);
            dat_log.push_back(wr_data_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Offers one byte and returns just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = b;
        for (int n = 0; n < 16 && !taken; n++) begin
            taken = (in_ready_o === 1'b1);
            tick();
        end
        in_valid_i = 1'b0;
        if (!taken) check("ready_wait", 32'(in_ready_o), 32'd1);
    endtask

    function automatic logic [15:0] word_of(input int pat, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        case (pat)
            0:       return 16'h1234;
            1:       return {ib, ib};
            2:       return 16'hABCD;
            3:       return {ib, 8'hF0};
            default: return 16'h1122;
        endcase
    endfunction

    // Sends words [from..to] of a pattern; gap inserts an idle cycle with
    // in_valid low after every byte.
    task automatic load_words(input int pat, input int from, input int to, input bit gap);
        logic [15:0] w;
        for (int i = from; i <= to; i++) begin
            w = word_of(pat, i);
            send_byte(w[15:8]);
            if (gap) tick();
            send_byte(w[7:0]);
            if (gap) tick();
        end
    endtask

    task automatic check_log(input string tag, input int pat, input int n);
        check({tag, "_count"}, 32'(adr_log.size()), 32'(n));
        for (int i = 0; i < n && i < adr_log.size(); i++) begin
            check($sformatf("%s_adr%0d", tag, i), 32'(adr_log[i]), 32'(i));
            check($sformatf("%s_dat%0d", tag, i), 32'(dat_log[i]), 32'(word_of(pat, i)));
        end
        adr_log.delete();
        dat_log.delete();
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"}, 32'(done_o), 32'(d));
        check({tag, "_err"}, 32'(err_o), 32'(e));
        check({tag, "_hold"}, 32'(core_hold_o), 32'(h));
    endtask

    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        tick();
        tick();
        reset_i = 1'b0;

        // 1: reset state, then a clean load of 0x1234 words.
        check_status("rst", 1'b0, 1'b0, 1'b1);
        check("rst_ready", 32'(in_ready_o), 32'd0);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_wr_adr", 32'(wr_adr_o), 32'd0);
        check("rst_wr_data", 32'(wr_data_o), 32'd0);
        pulse_start();
        check("t1_ready", 32'(in_ready_o), 32'd1);
        check_status("t1_loading", 1'b0, 1'b0, 1'b1);
        load_words(0, 0, 15, 1'b0);
        check("t1_check_ready", 32'(in_ready_o), 32'd1);
        send_byte(8'h00);
        check_status("t1_end", 1'b1, 1'b0, 1'b0);
        check("t1_end_ready", 32'(in_ready_o), 32'd0);
        check_log("t1", 0, 16);

        // 2: restart from DONE, bad checksum.
        pulse_start();
        check_status("t2_restart", 1'b0, 1'b0, 1'b1);
        load_words(0, 0, 15, 1'b0);
        send_byte(8'h01);
        check_status("t2_end", 1'b0, 1'b1, 1'b1);
        check_log("t2", 0, 16);

        // 3: words i*0x0101 with in_valid toggling.
        pulse_start();
        check_status("t3_restart", 1'b0, 1'b0, 1'b1);
        load_words(1, 0, 15, 1'b1);
        send_byte(8'h00);
        check_status("t3_end", 1'b1, 1'b0, 1'b0);
        check_log("t3", 1, 16);

        // 4: reset right after word 5 is written, then idle valid, then reload.
        pulse_start();
        load_words(2, 0, 5, 1'b0);
        check("t4_w5_en", 32'(wr_en_o), 32'd1);
        check("t4_w5_adr", 32'(wr_adr_o), 32'd5);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_status("t4_rst", 1'b0, 1'b0, 1'b1);
        check("t4_rst_ready", 32'(in_ready_o), 32'd0);
        check("t4_rst_wr_en", 32'(wr_en_o), 32'd0);
        check_log("t4_partial", 2, 6);

        // 5a: in_valid in IDLE is not consumed.
        in_valid_i = 1'b1;
        in_data_i  = 8'hAB;
        tick();
        tick();
        tick();
        check("t5_idle_ready", 32'(in_ready_o), 32'd0);
        check("t5_idle_wr_en", 32'(wr_en_o), 32'd0);
        in_valid_i = 1'b0;
        check("t5_idle_writes", 32'(adr_log.size()), 32'd0);

        pulse_start();
        load_words(2, 0, 15, 1'b0);
        send_byte(8'h00);
        check_status("t4_end", 1'b1, 1'b0, 1'b0);
        check_log("t4", 2, 16);

        // 5b: start pulses in LOAD_HI and LOAD_LO are ignored.
        pulse_start();
        load_words(3, 0, 2, 1'b0);
        pulse_start();
        check("t5_mid_hi_ready", 32'(in_ready_o), 32'd1);
        check_status("t5_mid_hi", 1'b0, 1'b0, 1'b1);
        send_byte(8'h03);
        pulse_start();
        check("t5_mid_lo_ready", 32'(in_ready_o), 32'd1);
        check("t5_mid_lo_wr_en", 32'(wr_en_o), 32'd0);
        send_byte(8'hF0);
        check("t5_w3_adr", 32'(wr_adr_o), 32'd3);
        load_words(3, 4, 15, 1'b0);
        send_byte(8'h00);
        check_status("t5_end", 1'b1, 1'b0, 1'b0);
        check_log("t5", 3, 16);

        // 6: stall after three bytes.
`ifdef UCODE_TIMEOUT_EN
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h11);
        for (int i = 0; i < 7; i++) tick();
        check("t6_before_err", 32'(err_o), 32'd0);
        check("t6_before_ready", 32'(in_ready_o), 32'd1);
        tick();
        check_status("t6_timeout", 1'b0, 1'b1, 1'b1);
        check("t6_timeout_ready", 32'(in_ready_o), 32'd0);
        tick();
        tick();
        check_log("t6_timeout", 4, 1);

        // A byte accepted in the final idle cycle beats the timeout.
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h11);
        for (int i = 0; i < 7; i++) tick();
        send_byte(8'h22);
        check("t6_win_err", 32'(err_o), 32'd0);
        check("t6_win_wr_en", 32'(wr_en_o), 32'd1);
        check("t6_win_adr", 32'(wr_adr_o), 32'd1);
        load_words(4, 2, 15, 1'b0);
        send_byte(8'h00);
        check_status("t6_win_end", 1'b1, 1'b0, 1'b0);
        check_log("t6_win", 4, 16);
`else
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h11);
        for (int i = 0; i < 20; i++) tick();
        check_status("t6_stall", 1'b0, 1'b0, 1'b1);
        check("t6_stall_ready", 32'(in_ready_o), 32'd1);
        check("t6_stall_writes", 32'(adr_log.size()), 32'd1);
        send_byte(8'h22);
        load_words(4, 2, 15, 1'b0);
        send_byte(8'h00);
        check_status("t6_end", 1'b1, 1'b0, 1'b0);
        check_log("t6", 4, 16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
